alu_iter: RTL and testbench



---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_mul_iter.sv | 60 ++++++
 rtl/alu_iter.sv | 115 +++++++++++
 tb/tb_alu_iter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: op codes, flag bit positions, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_EOR = 3'b100;
  localparam logic [2:0] OP_BIC = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier producing the low WIDTH bits of a*b.
// Latency: start edge plus WIDTH-1 edges; done is high on the edge of the final step.
// Backpressure: none; start must only be raised while idle.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  // count holds (steps taken - 1), so the last step is taken while count == WIDTH-2
  // and the counter reaches WIDTH-1 on that edge.
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 2);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [CW-1:0]    count;
  logic             busy;

  // Accumulator value after this cycle's conditional add.
  always_comb begin
    acc_nxt = acc;
    if (mplier[0]) acc_nxt = acc + mcand;
  end

  assign done    = busy && (count == LAST);
  assign product = acc_nxt;

  // Load performs the first step (bit 0 of b) so WIDTH steps finish WIDTH-1 edges later.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      count  <= '0;
      mcand  <= a << 1;
      mplier <= b >> 1;
      acc    <= b[0] ? a : '0;
    end else if (busy) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Handshaked ALU with registered result and NZCV flags; MUL runs on the iterative multiplier.
// Latency: 1 cycle for add/logic/illegal ops, WIDTH cycles for MUL.
// Backpressure: InReady low while a MUL is in flight; OutValid is a pulse with no stall.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       ALUControl,
  output logic             OutValid,
  output logic [WIDTH-1:0] ALUResult,
  output logic [3:0]       ALUFlags
);

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_comb;
  logic             arith;
  logic [3:0]       flags_comb;
  logic [3:0]       flags_mul;

  // Handshake: only the idle state accepts work.
  always_comb begin
    InReady   = (state == S_IDLE);
    accept    = InValid && InReady;
    mul_start = accept && (ALUControl == OP_MUL);
  end

  // Single-cycle datapath; SUB reuses the adder with B inverted and carry-in set.
  always_comb begin
    op_b     = (ALUControl == OP_SUB) ? ~SrcB : SrcB;
    sum      = {1'b0, SrcA} + {1'b0, op_b} + {{WIDTH{1'b0}}, (ALUControl == OP_SUB)};
    res_comb = '0;
    arith    = 1'b0;
    case (ALUControl)
      OP_ADD, OP_SUB: begin
        res_comb = sum[WIDTH-1:0];
        arith    = 1'b1;
      end
      OP_AND:  res_comb = SrcA & SrcB;
      OP_ORR:  res_comb = SrcA | SrcB;
      OP_EOR:  res_comb = SrcA ^ SrcB;
      OP_BIC:  res_comb = SrcA & ~SrcB;
      default: res_comb = '0;
    endcase
  end

  // Flags for both completion paths; an illegal op yields result 0 and so flags 0100.
  always_comb begin
    flags_comb         = '0;
    flags_comb[FLAG_N] = res_comb[WIDTH-1];
    flags_comb[FLAG_Z] = (res_comb == '0);
    flags_comb[FLAG_C] = arith && sum[WIDTH];
    flags_comb[FLAG_V] = arith && (SrcA[WIDTH-1] == op_b[WIDTH-1])
                               && (res_comb[WIDTH-1] != SrcA[WIDTH-1]);
    flags_mul          = '0;
    flags_mul[FLAG_N]  = mul_product[WIDTH-1];
    flags_mul[FLAG_Z]  = (mul_product == '0);
  end

  // Next-state: leave IDLE on a MUL accept, return when the multiplier finishes.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (mul_start) state_nxt = S_MUL;
      S_MUL:   if (mul_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and output registers; results hold until the next completion.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state     <= S_IDLE;
      OutValid  <= 1'b0;
      ALUResult <= '0;
      ALUFlags  <= '0;
    end else begin
      state    <= state_nxt;
      OutValid <= 1'b0;
      if (accept && !mul_start) begin
        ALUResult <= res_comb;
        ALUFlags  <= flags_comb;
        OutValid  <= 1'b1;
      end else if ((state == S_MUL) && mul_done) begin
        ALUResult <= mul_product;
        ALUFlags  <= flags_mul;
        OutValid  <= 1'b1;
      end
    end
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (CLK),
    .reset   (Reset),
    .start   (mul_start),
    .a       (SrcA),
    .b       (SrcB),
    .done    (mul_done),
    .product (mul_product)
  );

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter at WIDTH=32 and WIDTH=8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Every check uses hand-computed expectations.
module tb_alu_iter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  logic        iv32, ir32, ov32;
  logic [31:0] a32, b32, res32;
  logic [2:0]  op32;
  logic [3:0]  fl32;

  logic        iv8, ir8, ov8;
  logic [7:0]  a8, b8, res8;
  logic [2:0]  op8;
  logic [3:0]  fl8;

  int tests = 0;
  int fails = 0;

  alu_iter #(.WIDTH(32)) dut32 (
    .CLK(clk), .Reset(reset), .InValid(iv32), .InReady(ir32),
    .SrcA(a32), .SrcB(b32), .ALUControl(op32),
    .OutValid(ov32), .ALUResult(res32), .ALUFlags(fl32)
  );

  alu_iter #(.WIDTH(8)) dut8 (
    .CLK(clk), .Reset(reset), .InValid(iv8), .InReady(ir8),
    .SrcA(a8), .SrcB(b8), .ALUControl(op8),
    .OutValid(ov8), .ALUResult(res8), .ALUFlags(fl8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for one cycle on the 32-bit unit; returns just after the accepting edge.
  task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    op32 = op; a32 = a; b32 = b; iv32 = 1'b1;
    tick();
    iv32 = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    iv32 = 1'b0; a32 = '0; b32 = '0; op32 = OP_ADD;
    iv8  = 1'b0; a8  = '0; b8  = '0; op8  = OP_ADD;
    tick();
    tick();
    check("rst_inready", {31'd0, ir32}, 32'd1);
    check("rst_outvalid", {31'd0, ov32}, 32'd0);
    check("rst_result", res32, 32'h0);
    check("rst_flags", {28'd0, fl32}, 32'h0);
    reset = 1'b0;
    tick();

    // ADD with carry out to zero
    issue32(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
    check("add_ov", {31'd0, ov32}, 32'd1);
    check("add_res", res32, 32'h0000_0000);
    check("add_flags", {28'd0, fl32}, 32'h6);
    tick();
    check("add_pulse_end", {31'd0, ov32}, 32'd0);

    // SUB overflow and SUB borrow
    issue32(OP_SUB, 32'h8000_0000, 32'h0000_0001);
    check("sub1_res", res32, 32'h7FFF_FFFF);
    check("sub1_flags", {28'd0, fl32}, 32'h3);
    issue32(OP_SUB, 32'h0000_0001, 32'h0000_0002);
    check("sub2_res", res32, 32'hFFFF_FFFF);
    check("sub2_flags", {28'd0, fl32}, 32'h8);

    // Illegal op
    issue32(OP_ILL, 32'h1234_5678, 32'h9ABC_DEF0);
    check("ill_ov", {31'd0, ov32}, 32'd1);
    check("ill_res", res32, 32'h0);
    check("ill_flags", {28'd0, fl32}, 32'h4);

    // Back-to-back logic ops
    a32 = 32'hF0F0_F0F0; b32 = 32'hFF00_FF00; iv32 = 1'b1;
    op32 = OP_AND; tick();
    check("and_ov", {31'd0, ov32}, 32'd1);
    check("and_res", res32, 32'hF000_F000);
    op32 = OP_ORR; tick();
    check("orr_ov", {31'd0, ov32}, 32'd1);
    check("orr_res", res32, 32'hFFF0_FFF0);
    op32 = OP_EOR; tick();
    check("eor_ov", {31'd0, ov32}, 32'd1);
    check("eor_res", res32, 32'h0FF0_0FF0);
    op32 = OP_BIC; tick();
    check("bic_ov", {31'd0, ov32}, 32'd1);
    check("bic_res", res32, 32'h00F0_00F0);
    check("bic_flags", {28'd0, fl32}, 32'h0);
    iv32 = 1'b0; tick();
    check("b2b_idle_ov", {31'd0, ov32}, 32'd0);

    // MUL latency and result; ADD issued in the OutValid cycle
    issue32(OP_MUL, 32'h0001_0003, 32'h0000_0005);
    for (int i = 1; i <= 31; i++) begin
      check($sformatf("mul_busy_ready_c%0d", i), {31'd0, ir32}, 32'd0);
      check($sformatf("mul_busy_ov_c%0d", i), {31'd0, ov32}, 32'd0);
      tick();
    end
    check("mul_ov", {31'd0, ov32}, 32'd1);
    check("mul_ready", {31'd0, ir32}, 32'd1);
    check("mul_res", res32, 32'h0005_000F);
    check("mul_flags", {28'd0, fl32}, 32'h0);
    issue32(OP_ADD, 32'h0000_0002, 32'h0000_0003);
    check("post_mul_add_ov", {31'd0, ov32}, 32'd1);
    check("post_mul_add_res", res32, 32'h0000_0005);

    // Reset in cycle 10 of a MUL while a request is held
    issue32(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    check("pre_rst_res", res32, 32'h8000_0000);
    check("pre_rst_flags", {28'd0, fl32}, 32'h9);
    issue32(OP_MUL, 32'h0000_0003, 32'h0000_0003);
    op32 = OP_ADD; a32 = 32'h0000_0001; b32 = 32'h0000_0001; iv32 = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      check($sformatf("held_ov_c%0d", i), {31'd0, ov32}, 32'd0);
      check($sformatf("held_res_c%0d", i), res32, 32'h8000_0000);
      tick();
    end
    reset = 1'b1;
    tick();
    check("abort_ov", {31'd0, ov32}, 32'd0);
    check("abort_res", res32, 32'h0);
    check("abort_flags", {28'd0, fl32}, 32'h0);
    check("abort_ready", {31'd0, ir32}, 32'd1);
    reset = 1'b0; iv32 = 1'b0;
    tick();
    check("abort_after_ov", {31'd0, ov32}, 32'd0);
    check("abort_after_res", res32, 32'h0);

    // WIDTH=8: signed overflow on ADD
    op8 = OP_ADD; a8 = 8'h7F; b8 = 8'h01; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    check("w8_add_ov", {31'd0, ov8}, 32'd1);
    check("w8_add_res", {24'd0, res8}, 32'h80);
    check("w8_add_flags", {28'd0, fl8}, 32'h9);

    // WIDTH=8: MUL wraps to zero, latency 8
    op8 = OP_MUL; a8 = 8'h10; b8 = 8'h10; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      check($sformatf("w8_mul_busy_c%0d", i), {30'd0, ov8, ir8}, 32'd0);
      tick();
    end
    check("w8_mul_ov", {31'd0, ov8}, 32'd1);
    check("w8_mul_res", {24'd0, res8}, 32'h00);
    check("w8_mul_flags", {28'd0, fl8}, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
